// File: rtl/fetch_queue.sv
// Instruction fetch queue: a DEPTH-entry FIFO between fetch and decode.
// Registered outputs only; empty queue presents PC_START with a NOP word.
module fetch_queue #(
  parameter int          DEPTH    = 4,            // power of two, >= 2
  parameter logic [31:0] PC_START = 32'h00400020
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [31:0]     NOP        = 32'h0000_0000;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_q;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          push;
  logic          pop;

  // in_ready depends only on stored count, never on out_ready.
  assign in_ready  = (count_q < FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : PC_START;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : NOP;

  // NOTE: storage has no reset; count alone decides which entries are valid,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      // Pointers are AW bits wide, so DEPTH being a power of two gives a
      // natural modulo-DEPTH wrap.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;

  localparam logic [31:0] PC_START = 32'h00400020;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [2:0]  count;

  int vectors     = 0;
  int miscompares = 0;

  fetch_queue #(.DEPTH(4), .PC_START(PC_START)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance one rising edge; results are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr_of(pc);
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_in(1'b1, base + 32'(4 * i));
      step();
    end
    drive_in(1'b0, 32'h0);
  endtask

  task automatic expect_head_and_pop(input string tag, input logic [31:0] pc);
    out_ready = 1'b1;
    check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    check({tag, "_pc"},    out_pc,             pc);
    check({tag, "_instr"}, out_instr,          instr_of(pc));
    step();
    out_ready = 1'b0;
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
    check({tag, "_ready"}, {31'h0, in_ready},  32'h1);
    check({tag, "_count"}, {29'h0, count},     32'h0);
    check({tag, "_pc"},    out_pc,             PC_START);
    check({tag, "_instr"}, out_instr,          32'h0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive_in(1'b0, 32'h0);
    #2;
    expect_empty("rst_async");
    step(); step();
    reset = 1'b0;
    step();
    expect_empty("idle");

    // Fill to full, reject a fifth, then drain in order.
    fill(32'h00400020, 4);
    check("full_count", {29'h0, count}, 32'h4);
    check("full_ready", {31'h0, in_ready}, 32'h0);
    check("full_head",  out_pc, 32'h00400020);
    drive_in(1'b1, 32'h00400030);
    step();
    drive_in(1'b0, 32'h0);
    check("fifth_rej", {29'h0, count}, 32'h4);
    for (int i = 0; i < 4; i++)
      expect_head_and_pop($sformatf("drain%0d", i), 32'h00400020 + 32'(4 * i));
    expect_empty("drained");

    // Streaming: one entry in flight, pointers wrap twice.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_in(1'b1, 32'h0000_1000 + 32'(4 * i));
      step();
      check($sformatf("strm%0d_count", i), {29'h0, count}, 32'h1);
      check($sformatf("strm%0d_pc", i), out_pc, 32'h0000_1000 + 32'(4 * i));
    end
    drive_in(1'b0, 32'h0);
    step();
    out_ready = 1'b0;
    expect_empty("strm_end");

    // Full with push and pop together: pop wins, push refused.
    fill(32'h0000_2000, 4);
    out_ready = 1'b1;
    drive_in(1'b1, 32'h0000_2010);
    step();
    out_ready = 1'b0;
    check("fullpp_count", {29'h0, count}, 32'h3);
    check("fullpp_ready", {31'h0, in_ready}, 32'h1);
    drive_in(1'b1, 32'h0000_2014);
    step();
    drive_in(1'b0, 32'h0);
    check("fullpp_refill", {29'h0, count}, 32'h4);
    expect_head_and_pop("fpp0", 32'h0000_2004);
    expect_head_and_pop("fpp1", 32'h0000_2008);
    expect_head_and_pop("fpp2", 32'h0000_200C);
    expect_head_and_pop("fpp3", 32'h0000_2014);
    expect_empty("fpp_end");

    // Flush beats same-cycle push and pop.
    fill(32'h0000_3000, 3);
    check("pre_flush_count", {29'h0, count}, 32'h3);
    flush = 1'b1;
    out_ready = 1'b1;
    drive_in(1'b1, 32'h0000_300C);
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    drive_in(1'b0, 32'h0);
    expect_empty("flushed");
    flush = 1'b1;
    drive_in(1'b1, 32'h0000_3010);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("flush_hold%0d_count", i), {29'h0, count}, 32'h0);
      check($sformatf("flush_hold%0d_ready", i), {31'h0, in_ready}, 32'h1);
    end
    flush = 1'b0;
    drive_in(1'b1, 32'h0000_4000);
    step();
    drive_in(1'b0, 32'h0);
    expect_head_and_pop("post_flush", 32'h0000_4000);
    expect_empty("post_flush_end");

    // Asynchronous reset between edges with two entries held.
    fill(32'h0000_5000, 2);
    check("pre_rst_count", {29'h0, count}, 32'h2);
    #2;
    reset = 1'b1;
    #1;
    expect_empty("mid_rst");
    out_ready = 1'b1;
    drive_in(1'b1, 32'h0000_5008);
    step();
    check("rst_hold_count", {29'h0, count}, 32'h0);
    reset = 1'b0;
    out_ready = 1'b0;
    drive_in(1'b0, 32'h0);
    expect_empty("rst_rel");
    step();
    check("rst_rel_pc", out_pc, PC_START);
    drive_in(1'b1, 32'h0000_6000);
    step();
    drive_in(1'b0, 32'h0);
    check("first_push_count", {29'h0, count}, 32'h1);
    expect_head_and_pop("first_push", 32'h0000_6000);
    expect_empty("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
